// File: rtl/fbs_pkg.sv
// Shared definitions for the f-register backup stack and its sequencer.
package fbs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BACKUP  = 3'd1,
        ST_RESTORE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_LOAD    = 3'd4
    } fbs_state_e;

    localparam int unsigned FBS_DEPTH   = 16;
    localparam int unsigned FBS_DEPTH_W = 5;
    localparam int unsigned FBS_TIMEOUT = 4;

endpackage

// File: rtl/fbs_depth_ctr.sv
// Saturating up/down snapshot counter with full/empty decode.
module fbs_depth_ctr
    import fbs_pkg::*;
#(
    parameter int unsigned DEPTH   = FBS_DEPTH,
    parameter int unsigned DEPTH_W = FBS_DEPTH_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic               at_max;
    logic               at_min;

    assign at_max = (depth_q == DEPTH_W'(DEPTH));
    assign at_min = (depth_q == '0);

    // Next depth: move one step, never past 0 or DEPTH.
    always_comb begin
        depth_d = depth_q;
        if (inc_i && !dec_i && !at_max) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (dec_i && !inc_i && !at_min) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    // Depth register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign depth_o = depth_q;
    assign full_o  = at_max;
    assign empty_o = at_min;

endmodule

// File: rtl/fbs_ctrl.sv
// Call/return sequencer driving fbs backup/restore strobes and RF load.
module fbs_ctrl
    import fbs_pkg::*;
#(
    parameter int unsigned DEPTH   = FBS_DEPTH,
    parameter int unsigned DEPTH_W = FBS_DEPTH_W,
    parameter int unsigned TIMEOUT = FBS_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               call_req,
    input  logic               ret_req,
    output logic               call_ack,
    output logic               ret_ack,
    output logic               fbs_backup,
    output logic               fbs_restore,
    input  logic               fbs_restore_valid,
    output logic               rf_load,
    output logic               busy,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty,
    output logic               err_ovf,
    output logic               err_unf,
    output logic               err_timeout,
    input  logic               err_clr
);

    localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    fbs_state_e      state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [TO_W-1:0] to_cnt_inc;
    logic            call_ack_q, call_ack_d;
    logic            ret_ack_q, ret_ack_d;
    logic            backup_q, backup_d;
    logic            restore_q, restore_d;
    logic            rf_load_q, rf_load_d;
    logic            busy_q, busy_d;
    logic            err_ovf_q, err_ovf_d;
    logic            err_unf_q, err_unf_d;
    logic            err_to_q, err_to_d;
    logic            call_ovf, ret_unf, ret_to;
    logic            full_w, empty_w;

    fbs_depth_ctr #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_depth (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (state_q == ST_BACKUP),
        .dec_i   (state_q == ST_LOAD),
        .depth_o (depth),
        .full_o  (full_w),
        .empty_o (empty_w)
    );

    // Next state, error events and registered-output next values.
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        to_cnt_inc = to_cnt_q + TO_W'(1);
        call_ovf   = 1'b0;
        ret_unf    = 1'b0;
        ret_to     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // An ack still on the wire means its request is being retired;
                // arbitrating now would serve the same request twice.
                if (!(call_ack_q || ret_ack_q)) begin
                    if (ret_req) begin
                        if (empty_w) ret_unf = 1'b1;
                        else         state_d = ST_RESTORE;
                    end else if (call_req) begin
                        if (full_w) call_ovf = 1'b1;
                        else        state_d  = ST_BACKUP;
                    end
                end
            end
            ST_BACKUP:  state_d = ST_IDLE;
            ST_RESTORE: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                to_cnt_d = to_cnt_inc;
                if (fbs_restore_valid) begin
                    state_d = ST_LOAD;
                end else if (to_cnt_inc == TO_W'(TIMEOUT)) begin
                    ret_to  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        call_ack_d = (state_d == ST_BACKUP) || call_ovf;
        ret_ack_d  = (state_d == ST_LOAD) || ret_unf || ret_to;
        backup_d   = (state_d == ST_BACKUP);
        restore_d  = (state_d == ST_RESTORE) || (state_d == ST_WAIT);
        rf_load_d  = (state_d == ST_LOAD);
        busy_d     = (state_d != ST_IDLE);
        err_ovf_d  = call_ovf || (err_ovf_q && !err_clr);
        err_unf_d  = ret_unf  || (err_unf_q && !err_clr);
        err_to_d   = ret_to   || (err_to_q  && !err_clr);
    end

    // State, timeout counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            to_cnt_q   <= '0;
            call_ack_q <= 1'b0;
            ret_ack_q  <= 1'b0;
            backup_q   <= 1'b0;
            restore_q  <= 1'b0;
            rf_load_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_unf_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            call_ack_q <= call_ack_d;
            ret_ack_q  <= ret_ack_d;
            backup_q   <= backup_d;
            restore_q  <= restore_d;
            rf_load_q  <= rf_load_d;
            busy_q     <= busy_d;
            err_ovf_q  <= err_ovf_d;
            err_unf_q  <= err_unf_d;
            err_to_q   <= err_to_d;
        end
    end

    assign call_ack    = call_ack_q;
    assign ret_ack     = ret_ack_q;
    assign fbs_backup  = backup_q;
    assign fbs_restore = restore_q;
    assign rf_load     = rf_load_q;
    assign busy        = busy_q;
    assign full        = full_w;
    assign empty       = empty_w;
    assign err_ovf     = err_ovf_q;
    assign err_unf     = err_unf_q;
    assign err_timeout = err_to_q;

endmodule

// File: doc/fbs_ctrl.md
Name: fbs_ctrl

Overview:
- Sequencer for the f-register backup stack (fbs).
- Takes call/return requests from the CPU control unit and drives fbs backup/restore strobes. Tracks stack depth, waits for the fbs restore-valid indication, and pulses a register-file load.
- Sits between the control unit and fbs. Asserts busy so the pipeline stalls while a restore is in flight.

Parameters:
- DEPTH, 16, number of 256-bit snapshots fbs can hold.
- DEPTH_W, 5, width of the depth counter; must hold 0..DEPTH.
- TIMEOUT, 4, maximum cycles spent in WAIT for fbs_restore_valid before aborting.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- call_req  in  1  level request: snapshot f registers; held until call_ack.
- ret_req  in  1  level request: restore f registers; held until ret_ack.
- call_ack  out  1  one-cycle pulse; call request consumed.
- ret_ack  out  1  one-cycle pulse; return request consumed.
- fbs_backup  out  1  one-cycle backup strobe to fbs.
- fbs_restore  out  1  restore enable to fbs; held high through WAIT.
- fbs_restore_valid  in  1  fbs restoreOut; restored data valid on fbs dataOut.
- rf_load  out  1  one-cycle pulse; register file captures fbs dataOut.
- busy  out  1  high in every state except IDLE.
- depth  out  DEPTH_W  current number of stored snapshots.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- err_ovf  out  1  sticky; call attempted while full.
- err_unf  out  1  sticky; return attempted while empty.
- err_timeout  out  1  sticky; restore not acknowledged within TIMEOUT cycles.
- err_clr  in  1  synchronous clear of all three sticky error flags.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; depth = 0; timeout counter = 0.
  - All outputs 0 except empty = 1.
  - Reset mid-sequence abandons it; no strobe is issued after reset is released.
- All outputs are registered. full and empty are decoded from the registered depth.
- States: IDLE, BACKUP, RESTORE, WAIT, LOAD.
- IDLE, request arbitration:
  - ret_req has priority over call_req when both are high. The call stays pending and is served on a later IDLE cycle.
  - ret_req with empty: stay IDLE; ret_ack pulses next cycle; err_unf set; no fbs strobe.
  - ret_req with not empty: go to RESTORE.
  - call_req (no ret_req) with full: stay IDLE; call_ack pulses next cycle; err_ovf set; no fbs strobe.
  - call_req (no ret_req) with not full: go to BACKUP.
- BACKUP (1 cycle):
  - fbs_backup = 1 and call_ack = 1.
  - depth increments at end of cycle.
  - Next state IDLE.
  - Call latency: request seen in cycle N; strobe and ack in N+1; new depth visible in N+2.
- RESTORE (1 cycle): fbs_restore = 1; timeout counter cleared; next state WAIT.
- WAIT:
  - fbs_restore stays 1; counter increments each cycle.
  - If fbs_restore_valid is high: go to LOAD.
  - Else if counter reaches TIMEOUT: set err_timeout, pulse ret_ack, go to IDLE. depth is unchanged and rf_load is not asserted.
- LOAD (1 cycle):
  - rf_load = 1 and ret_ack = 1; fbs_restore drops to 0.
  - depth decrements at end of cycle.
  - Next state IDLE.
  - Minimum return latency, request to rf_load: 3 cycles (fbs valid on the first WAIT cycle).
- Requests arriving while busy are ignored until IDLE. Requesters must hold them.
- depth never wraps: it saturates at 0 and DEPTH, and overflow/underflow requests do not change it.
- err_clr is sampled every cycle. If an error event and err_clr occur in the same cycle, the set wins.
- A single call_ack or ret_ack pulse is issued per request. After the ack the requester must deassert for at least one cycle before requesting again.

Decomposition:
- Shared package fbs_pkg holds the state encoding (IDLE=0, BACKUP=1, RESTORE=2, WAIT=3, LOAD=4, 3-bit) and the default DEPTH/TIMEOUT constants. fbs and fbs_ctrl both use it.
- One natural sub-module: fbs_depth_ctr, a saturating up/down counter with full/empty decode.
- Everything else stays in fbs_ctrl.

Test Plan:
- Reset then idle → depth=0, empty=1, full=0, all strobes 0; asserting reset_n low mid-WAIT returns all outputs to reset values in the same cycle.
- Call while depth=0 → fbs_backup and call_ack high exactly 1 cycle after request; depth=1 two cycles after request; 16 calls → full=1, depth=16.
- Call when depth=16 → call_ack pulses, err_ovf=1, no fbs_backup, depth stays 16; err_clr clears err_ovf the next cycle.
- Return with depth=3 and fbs_restore_valid returned 1 cycle after fbs_restore → rf_load and ret_ack 3 cycles after request; depth=2; busy high throughout.
- call_req and ret_req asserted together at depth=2 → return served first (depth 1), then call (depth 2); exactly one ack of each.
- Return with fbs_restore_valid held 0 → err_timeout after TIMEOUT=4 WAIT cycles, ret_ack pulses, rf_load never high, depth unchanged; return at depth=0 → err_unf, no fbs_restore.
